pavio: RTL
==========

# pavio

Fuse-countdown generator for the bomb game datapath. Once armed, it burns down a 7-segment LED bar, one LED per tick. It asserts `explosion` when the bar empties, or freezes the bar if defused first. Its `leds` and `explosion` outputs are the producer side of the LED-forcing stage, which drives LEDR[6..0].

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per fuse step; legal range ≥ 2.
- `STEPS`, fixed at 7 (not overridable): fuse length in LEDs.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  level; sampled only in IDLE; starts the fuse.
- `defuse`  in  1  level; sampled only in BURNING; stops the fuse.
- `clear`  in  1  level; sampled only in EXPLODED or DEFUSED; returns to IDLE.
- `leds`  out  7  thermometer bar of remaining fuse; bit 0 is the last to go out.
- `explosion`  out  1  high while in EXPLODED.
- `burning`  out  1  high while in BURNING.
- `defused`  out  1  high while in DEFUSED.

## Operation
- All outputs are registered. Reset values: `leds`=0, `explosion`=0, `burning`=0, `defused`=0, state=IDLE, remaining=0, prescaler=0.
- State machine:
  - IDLE → BURNING on `arm`. Load remaining=7 and `leds`=7'h7F, and clear the prescaler.
  - BURNING → DEFUSED on `defuse`. `leds` freeze at their current value.
  - BURNING → EXPLODED on the tick that takes remaining from 1 to 0. Set `leds`=0 and `explosion`=1.
  - EXPLODED or DEFUSED → IDLE on `clear`. All outputs go to 0.
- Prescaler: counts 0..TICK_DIV-1 in BURNING only and wraps to 0. It produces a one-cycle tick when the count equals TICK_DIV-1. It is held at 0 outside BURNING.
- On each tick: remaining decrements by 1, and `leds` = (1 << remaining) − 1 using the new value.
- Widths: remaining is 3 bits, so no underflow past 0 is possible. Prescaler width is $clog2(TICK_DIV).
- Boundary and priority rules:
  - `defuse` and the final tick in the same cycle: defuse wins. Result is DEFUSED with `leds`=7'h01.
  - `arm` outside IDLE is ignored.
  - `defuse` outside BURNING is ignored.
  - `clear` in IDLE or BURNING is ignored.
  - `clear` and `arm` in the same cycle in a terminal state: go to IDLE only. The fuse needs a fresh `arm` on a later cycle.
  - Inputs held high are level-sensitive, so `arm` held through `clear` re-arms one cycle after reaching IDLE.
  - `reset` in any state, including mid-burn: IDLE with all outputs 0 on the following cycle. `reset` overrides every other input.

## Timing
- Let E0 be the edge that samples `arm` in IDLE.
- After E0: `burning`=1 and `leds`=7'h7F.
- After edge E0 + k·TICK_DIV, for k = 1..6: `leds` show 7−k lit LEDs.
- After edge E0 + 7·TICK_DIV: `explosion`=1, `burning`=0, `leds`=0.
- `defuse` sampled at edge E takes effect after E. There is no further change to `leds`.
- `clear` latency is 1 cycle.

## Configuration
- `PAVIO_BLINK_EN` defined:
  - In BURNING with remaining ≤ 2, the lit LEDs blink.
  - They are masked to 0 while prescaler ≥ TICK_DIV/2 and shown otherwise.
  - Remaining, tick, and explosion timing are unchanged.
- `PAVIO_BLINK_EN` not defined: `leds` are steady between ticks.

## Structure
- Shared package `pavio_pkg` holds:
  - the state enum `pavio_state_t` (IDLE, BURNING, EXPLODED, DEFUSED);
  - the constant `PAVIO_STEPS` = 7;
  - the function `therm7(logic [2:0] n)`, which returns (1 << n) − 1.
- Sub-module `pavio_prescaler` (ports: `clk`, `reset`, `en`, `tick`, and the count output used for blink) holds the divider.
- The top module holds the FSM, the remaining counter, and the output registers.

## Test plan
All scenarios use TICK_DIV=4.
- Full burn: reset, then `arm` one cycle. Expect `leds` = 7F, 3F, 1F, 0F, 07, 03, 01 at 4-cycle spacing, then `explosion`=1 and `leds`=0 exactly 28 cycles after the arm edge.
- Defuse mid-burn: `defuse` at cycle 10 after arm. Expect `defused`=1, `leds`=7'h1F frozen for 20+ cycles, and `explosion` never set.
- Collision: `defuse` on the same cycle as the 7th tick. Expect DEFUSED with `leds`=7'h01 and `explosion`=0.
- Reset mid-burn: `reset` at cycle 13. Expect all outputs 0 the next cycle. A later `arm` restarts from 7F with full 28-cycle timing.
- Ignored inputs and clear/arm: `arm` pulses during BURNING leave the sequence unchanged. `clear` during BURNING is ignored. In EXPLODED, `clear`+`arm` together give IDLE for one cycle, and `arm` on the next cycle re-arms.
- With `PAVIO_BLINK_EN`: at remaining=2, `leds` alternate 03/00 in 2-cycle halves. The explosion cycle is unchanged at 28.

Source files
------------

// File: rtl/pavio_pkg.sv
// Shared types, constants and helpers for the pavio fuse-countdown block.
package pavio_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BURNING  = 2'd1,
      EXPLODED = 2'd2,
      DEFUSED  = 2'd3
   } pavio_state_t;

   localparam logic [2:0] PAVIO_STEPS = 3'd7;

   // Thermometer code with the n lowest bits lit; n = 7 lights the whole bar.
   function automatic logic [6:0] therm7(logic [2:0] n);
      logic [7:0] one_hot;
      one_hot = 8'd1 << n;
      return one_hot[6:0] - 7'd1;
   endfunction

endpackage

// File: rtl/pavio_prescaler.sv
// Fuse-step divider: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
module pavio_prescaler #(
   parameter int TICK_DIV = 50_000_000,
   parameter int CW       = $clog2(TICK_DIV)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic          tick,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick  = en && (cnt_q == LAST);
   assign count = cnt_q;

   always_comb begin
      cnt_d = (!en || tick) ? '0 : cnt_q + CW'(1);
   end

   // NOTE: synchronous reset lives inside the clocked block; nonblocking only.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pavio.sv
// Fuse-countdown generator: burns a 7-LED bar down one LED per prescaler tick.
// Define PAVIO_BLINK_EN to blink the last two LEDs during the second half of each step.
module pavio
   import pavio_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arm,
   input  logic       defuse,
   input  logic       clear,
   output logic [6:0] leds,
   output logic       explosion,
   output logic       burning,
   output logic       defused
);

   localparam int CW = $clog2(TICK_DIV);

`ifdef PAVIO_BLINK_EN
   localparam bit BLINK_EN = 1'b1;
`else
   localparam bit BLINK_EN = 1'b0;
`endif

   localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

   pavio_state_t  state_q, state_d;
   logic [2:0]    rem_q, rem_d;
   logic [6:0]    leds_q, leds_d;
   logic          explosion_q, burning_q, defused_q;

   logic          presc_en;
   logic          tick;
   logic [CW-1:0] presc_cnt;
   logic [CW-1:0] cnt_nxt;

   // A defuse zeroes the divider on the same edge, so it is 0 in every state but BURNING.
   assign presc_en = (state_q == BURNING) && !defuse;

   pavio_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CW       (CW)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (presc_en),
      .tick  (tick),
      .count (presc_cnt)
   );

   // Count value the divider will hold after this edge; blink phase keys off it.
   assign cnt_nxt = tick ? '0 : presc_cnt + CW'(1);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      leds_d  = leds_q;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d = BURNING;
               rem_d   = PAVIO_STEPS;
               leds_d  = therm7(PAVIO_STEPS);
            end
         end
         BURNING: begin
            if (defuse) begin
               state_d = DEFUSED;
            end else begin
               if (tick) rem_d = rem_q - 3'd1;
               if (tick && rem_q == 3'd1) begin
                  state_d = EXPLODED;
                  leds_d  = '0;
               end else if (BLINK_EN && rem_d <= 3'd2 && cnt_nxt >= HALF) begin
                  leds_d = '0;
               end else begin
                  leds_d = therm7(rem_d);
               end
            end
         end
         EXPLODED, DEFUSED: begin
            if (clear) begin
               state_d = IDLE;
               rem_d   = '0;
               leds_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         leds_q      <= '0;
         explosion_q <= 1'b0;
         burning_q   <= 1'b0;
         defused_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         leds_q      <= leds_d;
         explosion_q <= (state_d == EXPLODED);
         burning_q   <= (state_d == BURNING);
         defused_q   <= (state_d == DEFUSED);
      end
   end

   assign leds      = leds_q;
   assign explosion = explosion_q;
   assign burning   = burning_q;
   assign defused   = defused_q;

endmodule
